scoreboard_warp_param: RTL

Parametrised per-warp scoreboard that generalises the 4-entry fixed scoreboard.
- Tracks up to SB_DEPTH in-flight instructions (src1/src2/dst register tags).
- Checks every instruction-buffer entry for RAW/WAW/WAR hazards, both against in-flight instructions and against older valid IB entries.
- Allocates entry numbers to the operand collector.
- Accepts NUM_WB independent release ports from writeback.
- Adds a warp flush, an occupancy count, optional release bypass, and sticky protocol-error flags.

---
 rtl/gpgpu_sb_pkg.sv | 50 +++++
 rtl/scoreboard_warp_param_if.sv | 39 +++
 rtl/sb_prio_alloc.sv | 23 ++
 rtl/scoreboard_warp_param.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/gpgpu_sb_pkg.sv
// Shared types and helpers for the per-warp scoreboard.
//   tag_t       : unpacked register tag (valid flag + index)
//   tag_w       : packed tag width for a given register index width
//   unpack_tag  : packed tag -> tag_t; index bits above reg_aw are zeroed
//   tags_match  : both tags valid and their indices are equal
//   tag_hazard  : RAW | WAW | WAR between a younger and an older instruction
package gpgpu_sb_pkg;

    // Widest register index supported by the helpers. REG_AW must not exceed it.
    localparam int MAX_REG_AW = 15;
    localparam int MAX_TAG_W  = MAX_REG_AW + 1;

    typedef struct packed {
        logic                  valid;
        logic [MAX_REG_AW-1:0] idx;
    } tag_t;

    function automatic int tag_w(input int reg_aw);
        return reg_aw + 1;
    endfunction

    // raw holds a tag zero-extended to MAX_TAG_W; bit reg_aw is its valid flag.
    function automatic tag_t unpack_tag(input logic [MAX_TAG_W-1:0] raw, input int reg_aw);
        tag_t t;
        t = '0;
        for (int b = 0; b < MAX_REG_AW; b++) begin
            if (b < reg_aw) t.idx[b] = raw[b];
        end
        for (int b = 0; b < MAX_TAG_W; b++) begin
            if (b == reg_aw) t.valid = raw[b];
        end
        return t;
    endfunction

    function automatic logic tags_match(input tag_t a, input tag_t b);
        return a.valid && b.valid && (a.idx == b.idx);
    endfunction

    // Young instruction (src1, src2, dst_young) against an older one.
    function automatic logic tag_hazard(input tag_t src1, input tag_t src2,
                                        input tag_t dst_young, input tag_t dst_old,
                                        input tag_t src1_old, input tag_t src2_old);
        logic raw_h, waw_h, war_h;
        raw_h = tags_match(src1, dst_old) || tags_match(src2, dst_old);
        waw_h = tags_match(dst_young, dst_old);
        war_h = tags_match(dst_young, src1_old) || tags_match(dst_young, src2_old);
        return raw_h || waw_h || war_h;
    endfunction

endpackage

// File: rtl/scoreboard_warp_param_if.sv
// Issue / writeback bundle between the warp's instruction buffer, the
// writeback stage and the scoreboard.
//   ib_inst_valid, ib_src1/src2/dst, ib_issued : instruction buffer view
//   sb_ready_issue, sb_full, sb_count, sb_entnum_oc : scoreboard status
//   wb_release, wb_release_entnum : writeback release ports
// master = issue/writeback side, slave = scoreboard.
interface scoreboard_warp_param_if #(
    parameter int SB_DEPTH = 4,
    parameter int IB_DEPTH = 4,
    parameter int REG_AW   = 5,
    parameter int NUM_WB   = 2
);
    localparam int TAG_W = REG_AW + 1;
    localparam int EW    = $clog2(SB_DEPTH);

    logic [IB_DEPTH-1:0]       ib_inst_valid;
    logic [IB_DEPTH*TAG_W-1:0] ib_src1;
    logic [IB_DEPTH*TAG_W-1:0] ib_src2;
    logic [IB_DEPTH*TAG_W-1:0] ib_dst;
    logic [IB_DEPTH-1:0]       ib_issued;
    logic [IB_DEPTH-1:0]       sb_ready_issue;
    logic                      sb_full;
    logic [EW:0]               sb_count;
    logic [EW-1:0]             sb_entnum_oc;
    logic [NUM_WB-1:0]         wb_release;
    logic [NUM_WB*EW-1:0]      wb_release_entnum;

    modport master (
        output ib_inst_valid, ib_src1, ib_src2, ib_dst, ib_issued,
        output wb_release, wb_release_entnum,
        input  sb_ready_issue, sb_full, sb_count, sb_entnum_oc
    );

    modport slave (
        input  ib_inst_valid, ib_src1, ib_src2, ib_dst, ib_issued,
        input  wb_release, wb_release_entnum,
        output sb_ready_issue, sb_full, sb_count, sb_entnum_oc
    );
endinterface

// File: rtl/sb_prio_alloc.sv
// Lowest-free-index encoder for scoreboard allocation.
//   valid : per-entry occupied flags
//   idx   : lowest index with valid=0 (0 when all entries are occupied)
//   full  : all entries occupied
module sb_prio_alloc #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    output logic [IW-1:0] idx,
    output logic          full
);
    always_comb begin
        // NOTE: idx gets a default before the loop so no path leaves it unassigned (no latch).
        idx = '0;
        // Scan downward so the last hit, and thus the winner, is the lowest free index.
        for (int i = N - 1; i >= 0; i--) begin
            if (!valid[i]) idx = IW'(i);
        end
    end

    assign full = &valid;
endmodule

// File: rtl/scoreboard_warp_param.sv
// Parametrised per-warp scoreboard.
// Tracks up to SB_DEPTH in-flight instructions, flags RAW/WAW/WAR hazards for
// every instruction-buffer entry (against in-flight entries and older IB
// entries), allocates entry numbers to the operand collector and accepts
// NUM_WB writeback release ports.
//   clk, rst        : clock, synchronous active-high reset
//   sb (slave)      : issue / status / release bundle
//   flush           : warp kill, clears every entry at the next edge
//   err_issue_full  : sticky, issue attempted while full
//   err_bad_release : sticky, release of an invalid entry or duplicate release
//   err_multi_issue : sticky, ib_issued had more than one bit set
module scoreboard_warp_param
    import gpgpu_sb_pkg::*;
#(
    parameter int SB_DEPTH       = 4,
    parameter int IB_DEPTH       = 4,
    parameter int REG_AW         = 5,
    parameter int NUM_WB         = 2,
    parameter bit RELEASE_BYPASS = 1'b0
) (
    input  logic                           clk,
    input  logic                           rst,
    scoreboard_warp_param_if.slave         sb,
    input  logic                           flush,
    output logic                           err_issue_full,
    output logic                           err_bad_release,
    output logic                           err_multi_issue
);
    localparam int TAG_W = REG_AW + 1;
    localparam int EW    = $clog2(SB_DEPTH);
    localparam int CW    = EW + 1;

    // Registered state
    logic [SB_DEPTH-1:0] sb_valid;
    logic [TAG_W-1:0]    sb_src1 [SB_DEPTH];
    logic [TAG_W-1:0]    sb_src2 [SB_DEPTH];
    logic [TAG_W-1:0]    sb_dst  [SB_DEPTH];
    logic [CW-1:0]       count;

    // Allocation from the pre-edge state only, so a same-cycle release never
    // becomes the issue target.
    logic [EW-1:0] alloc_idx;
    logic          alloc_full;

    sb_prio_alloc #(.N(SB_DEPTH)) u_alloc (
        .valid (sb_valid),
        .idx   (alloc_idx),
        .full  (alloc_full)
    );

    // Issue decode
    logic                issue_any;
    logic                issue_onehot;
    logic                issue_ok;
    logic [TAG_W-1:0]    sel_src1, sel_src2, sel_dst;
    logic [SB_DEPTH-1:0] issue_set;

    always_comb begin
        issue_any    = |sb.ib_issued;
        issue_onehot = issue_any && ((sb.ib_issued & (sb.ib_issued - IB_DEPTH'(1))) == '0);
        issue_ok     = issue_onehot && !alloc_full && !flush;
        sel_src1     = '0;
        sel_src2     = '0;
        sel_dst      = '0;
        for (int k = 0; k < IB_DEPTH; k++) begin
            if (sb.ib_issued[k]) begin
                sel_src1 = sb.ib_src1[k*TAG_W +: TAG_W];
                sel_src2 = sb.ib_src2[k*TAG_W +: TAG_W];
                sel_dst  = sb.ib_dst[k*TAG_W +: TAG_W];
            end
        end
        issue_set = issue_ok ? (SB_DEPTH'(1) << alloc_idx) : '0;
    end

    // Release decode: rel_mask holds each distinct valid entry released this
    // cycle; invalid targets and repeats only raise the error.
    logic [SB_DEPTH-1:0] rel_mask;
    logic                rel_err;
    logic [EW-1:0]       rel_ent;
    logic [CW-1:0]       rel_cnt;
    logic [CW-1:0]       count_nxt;

    always_comb begin
        rel_mask = '0;
        rel_err  = 1'b0;
        rel_ent  = '0;
        for (int p = 0; p < NUM_WB; p++) begin
            if (sb.wb_release[p]) begin
                rel_ent = sb.wb_release_entnum[p*EW +: EW];
                if (!sb_valid[rel_ent] || rel_mask[rel_ent]) begin
                    rel_err = 1'b1;
                end else begin
                    rel_mask[rel_ent] = 1'b1;
                end
            end
        end
        rel_cnt = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            rel_cnt = rel_cnt + CW'(rel_mask[i]);
        end
        count_nxt = count + CW'(issue_ok) - rel_cnt;
    end

    // Hazard check
    tag_t ib_s1 [IB_DEPTH];
    tag_t ib_s2 [IB_DEPTH];
    tag_t ib_d  [IB_DEPTH];
    tag_t sb_s1 [SB_DEPTH];
    tag_t sb_s2 [SB_DEPTH];
    tag_t sb_d  [SB_DEPTH];

    always_comb begin
        for (int k = 0; k < IB_DEPTH; k++) begin
            ib_s1[k] = unpack_tag(MAX_TAG_W'(sb.ib_src1[k*TAG_W +: TAG_W]), REG_AW);
            ib_s2[k] = unpack_tag(MAX_TAG_W'(sb.ib_src2[k*TAG_W +: TAG_W]), REG_AW);
            ib_d[k]  = unpack_tag(MAX_TAG_W'(sb.ib_dst[k*TAG_W +: TAG_W]), REG_AW);
        end
        for (int i = 0; i < SB_DEPTH; i++) begin
            sb_s1[i] = unpack_tag(MAX_TAG_W'(sb_src1[i]), REG_AW);
            sb_s2[i] = unpack_tag(MAX_TAG_W'(sb_src2[i]), REG_AW);
            sb_d[i]  = unpack_tag(MAX_TAG_W'(sb_dst[i]), REG_AW);
        end
    end

    logic [IB_DEPTH-1:0] ready;

    always_comb begin
        ready = '1;
        for (int j = 0; j < IB_DEPTH; j++) begin
            if (sb.ib_inst_valid[j]) begin
                for (int i = 0; i < SB_DEPTH; i++) begin
                    // With bypass, an entry retiring this cycle no longer blocks.
                    if (sb_valid[i] && !(RELEASE_BYPASS && rel_mask[i]) &&
                        tag_hazard(ib_s1[j], ib_s2[j], ib_d[j], sb_d[i], sb_s1[i], sb_s2[i])) begin
                        ready[j] = 1'b0;
                    end
                end
                // Older IB entries (lower index) act like in-flight instructions.
                for (int i = 0; i < IB_DEPTH; i++) begin
                    if (i < j && sb.ib_inst_valid[i] &&
                        tag_hazard(ib_s1[j], ib_s2[j], ib_d[j], ib_d[i], ib_s1[i], ib_s2[i])) begin
                        ready[j] = 1'b0;
                    end
                end
            end
        end
    end

    // Control state and sticky error flags
    always_ff @(posedge clk) begin
        // NOTE: registered state is updated only with non-blocking assignments.
        if (rst) begin
            sb_valid        <= '0;
            count           <= '0;
            err_issue_full  <= 1'b0;
            err_bad_release <= 1'b0;
            err_multi_issue <= 1'b0;
        end else begin
            if (issue_onehot && alloc_full) err_issue_full  <= 1'b1;
            if (issue_any && !issue_onehot) err_multi_issue <= 1'b1;
            if (rel_err)                    err_bad_release <= 1'b1;
            if (flush) begin
                sb_valid <= '0;
                count    <= '0;
            end else begin
                sb_valid <= (sb_valid & ~rel_mask) | issue_set;
                count    <= count_nxt;
            end
        end
    end

    // NOTE: tag storage is left unreset; every read is qualified by sb_valid.
    always_ff @(posedge clk) begin
        if (issue_ok) begin
            sb_src1[alloc_idx] <= sel_src1;
            sb_src2[alloc_idx] <= sel_src2;
            sb_dst[alloc_idx]  <= sel_dst;
        end
    end

    assign sb.sb_ready_issue = ready;
    assign sb.sb_full        = alloc_full;
    assign sb.sb_count       = count;
    assign sb.sb_entnum_oc   = alloc_idx;
endmodule
